// File: rtl/snn_timestep_scheduler.sv
// -----------------------------------------------------------------------------
// snn_timestep_scheduler
//
// Clocked sequencer for the memory-side row-streaming datapath of the SNN
// accelerator. It first loads FILT_ROWS kernel rows (row r goes to PE r). It
// then streams IF_ROWS ifmap rows for each timestep. Rows at or beyond
// FILT_ROWS all go to the last PE and are paced by that PE's credit pulses.
// After the stream, the block waits for DONE_CNT DONE tokens, advances the
// timestep, and parks in FINISH after TIMESTEPS timesteps.
//
// Optional feature (macro SCHED_PERF_CNT_EN):
//   When defined, adds output stall_cnt[15:0]. It counts cycles lost to zero
//   credit while streaming, plus cycles with valid && !ready. It saturates at
//   16'hFFFF and clears on each timestep close.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             start pulse (IDLE: begin, FINISH: return to IDLE)
//   req_valid/ready   row-read request handshake
//   req_type          2'b01 kernel row, 2'b00 ifmap row
//   req_row           row index
//   req_t             timestep of an ifmap request (0 for kernel rows)
//   req_dest          destination PE address
//   pe5_cred          one-cycle pulse: last PE can accept one more row
//   done_tok          one-cycle pulse: one DONE packet received
//   cur_t             current timestep
//   ts_adv            one-cycle pulse when a timestep closes
//   busy / finished   activity / completion status
//   done_ovf          sticky: too many DONE tokens within one timestep
//   stall_cnt         (SCHED_PERF_CNT_EN only) stall cycle counter
// -----------------------------------------------------------------------------
module snn_timestep_scheduler #(
  parameter int TIMESTEPS = 2,
  parameter int FILT_ROWS = 5,
  parameter int IF_ROWS   = 25,
  parameter int DONE_CNT  = 7,
  parameter int CRED_MAX  = 4,
  parameter int TS_W      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic            req_valid,
  input  logic            req_ready,
  output logic [1:0]      req_type,
  output logic [4:0]      req_row,
  output logic [TS_W-1:0] req_t,
  output logic [3:0]      req_dest,
  input  logic            pe5_cred,
  input  logic            done_tok,
  output logic [TS_W-1:0] cur_t,
  output logic            ts_adv,
  output logic            busy,
  output logic            finished,
  output logic            done_ovf
`ifdef SCHED_PERF_CNT_EN
  ,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int CRED_W = $clog2(CRED_MAX + 1);
  localparam int DONE_W = $clog2(DONE_CNT + 1);

  localparam logic [4:0]        ROW_FILT   = 5'(FILT_ROWS);
  localparam logic [4:0]        ROW_K_LAST = 5'(FILT_ROWS - 1);
  localparam logic [4:0]        ROW_I_LAST = 5'(IF_ROWS - 1);
  localparam logic [CRED_W-1:0] CRED_SAT   = CRED_W'(CRED_MAX);
  localparam logic [DONE_W-1:0] DONE_FULL  = DONE_W'(DONE_CNT);
  localparam logic [TS_W-1:0]   T_LAST     = TS_W'(TIMESTEPS - 1);

  localparam logic [1:0] TYPE_KERNEL = 2'b01;
  localparam logic [1:0] TYPE_INPUT  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_STREAM,
    ST_WAIT_DONE,
    ST_FINISH
  } state_e;

  // Fixed NoC addresses of the five PEs, indexed by kernel row.
  function automatic logic [3:0] pe_addr(input logic [4:0] idx);
    case (idx)
      5'd0:    pe_addr = 4'b0001;
      5'd1:    pe_addr = 4'b0101;
      5'd2:    pe_addr = 4'b0011;
      5'd3:    pe_addr = 4'b0111;
      default: pe_addr = 4'b1100;
    endcase
  endfunction

  state_e              state_q, state_d;
  logic [4:0]          row_q, row_d;
  logic [CRED_W-1:0]   cred_q, cred_d;
  logic [DONE_W-1:0]   done_q, done_d;
  logic [TS_W-1:0]     cur_t_q, cur_t_d;
  logic                ovf_q, ovf_d;
  logic                ts_adv_q, ts_adv_d;
  logic                req_valid_q, req_valid_d;
  logic [1:0]          req_type_q, req_type_d;
  logic [4:0]          req_row_q, req_row_d;
  logic [TS_W-1:0]     req_t_q, req_t_d;
  logic [3:0]          req_dest_q, req_dest_d;
  logic                busy_q, busy_d;
  logic                finished_q, finished_d;

  logic hs;         // request handshake this cycle
  logic consume;    // handshake on a credit-paced row
  logic count_tok;  // token arrives while tokens are being counted
  logic close;      // timestep closes this cycle

  assign hs        = req_valid_q && req_ready;
  assign consume   = hs && (state_q == ST_STREAM) && (row_q >= ROW_FILT);
  assign count_tok = done_tok && ((state_q == ST_STREAM) || (state_q == ST_WAIT_DONE));
  assign close     = (state_q == ST_WAIT_DONE) && (done_q == DONE_FULL);

  // NOTE: every signal gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    cred_d   = cred_q;
    done_d   = done_q;
    cur_t_d  = cur_t_q;
    ovf_d    = ovf_q;
    ts_adv_d = 1'b0;

    // Credits: saturating increment. A simultaneous increment and consume
    // cancel out. Credits survive timestep changes and clear only in IDLE.
    if (state_q == ST_IDLE) begin
      cred_d = '0;
    end else if (pe5_cred && !consume) begin
      if (cred_q != CRED_SAT) cred_d = cred_q + CRED_W'(1);
    end else if (!pe5_cred && consume) begin
      cred_d = cred_q - CRED_W'(1);
    end

    // DONE tokens. Early tokens (during STREAM) are kept. On close, a token
    // arriving in the same cycle is credited to the next timestep.
    if (state_q == ST_IDLE) begin
      done_d = '0;
    end else if (close) begin
      done_d = (count_tok && (cur_t_q != T_LAST)) ? DONE_W'(1) : '0;
    end else if (count_tok) begin
      if (done_q == DONE_FULL) ovf_d = 1'b1;
      else                     done_d = done_q + DONE_W'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD_K;
          row_d   = '0;
        end
      end
      ST_LOAD_K: begin
        if (hs) begin
          if (row_q == ROW_K_LAST) begin
            row_d   = '0;
            cur_t_d = '0;
            state_d = ST_STREAM;
          end else begin
            row_d = row_q + 5'd1;
          end
        end
      end
      ST_STREAM: begin
        if (hs) begin
          if (row_q == ROW_I_LAST) begin
            row_d   = '0;
            state_d = ST_WAIT_DONE;
          end else begin
            row_d = row_q + 5'd1;
          end
        end
      end
      ST_WAIT_DONE: begin
        if (close) begin
          ts_adv_d = 1'b1;
          if (cur_t_q == T_LAST) begin
            state_d = ST_FINISH;
          end else begin
            cur_t_d = cur_t_q + TS_W'(1);
            row_d   = '0;
            state_d = ST_STREAM;
          end
        end
      end
      ST_FINISH: begin
        if (start) begin
          state_d = ST_IDLE;
          cur_t_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state, so they are registered, yet a
    // new request appears in the cycle right after a handshake. Credit can
    // only fall through a handshake, so valid cannot drop while stalled.
    req_valid_d = (state_d == ST_LOAD_K) ||
                  ((state_d == ST_STREAM) && ((row_d < ROW_FILT) || (cred_d != '0)));
    req_type_d  = (state_d == ST_LOAD_K) ? TYPE_KERNEL : TYPE_INPUT;
    req_row_d   = ((state_d == ST_LOAD_K) || (state_d == ST_STREAM)) ? row_d : '0;
    req_t_d     = (state_d == ST_STREAM) ? cur_t_d : '0;
    if (state_d == ST_LOAD_K)
      req_dest_d = pe_addr(row_d);
    else if (state_d == ST_STREAM)
      req_dest_d = pe_addr((row_d >= ROW_FILT) ? ROW_K_LAST : row_d);
    else
      req_dest_d = '0;
    busy_d      = (state_d == ST_LOAD_K) || (state_d == ST_STREAM) ||
                  (state_d == ST_WAIT_DONE);
    finished_d  = (state_d == ST_FINISH);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= '0;
      cred_q      <= '0;
      done_q      <= '0;
      cur_t_q     <= '0;
      ovf_q       <= 1'b0;
      ts_adv_q    <= 1'b0;
      req_valid_q <= 1'b0;
      req_type_q  <= '0;
      req_row_q   <= '0;
      req_t_q     <= '0;
      req_dest_q  <= '0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      cred_q      <= cred_d;
      done_q      <= done_d;
      cur_t_q     <= cur_t_d;
      ovf_q       <= ovf_d;
      ts_adv_q    <= ts_adv_d;
      req_valid_q <= req_valid_d;
      req_type_q  <= req_type_d;
      req_row_q   <= req_row_d;
      req_t_q     <= req_t_d;
      req_dest_q  <= req_dest_d;
      busy_q      <= busy_d;
      finished_q  <= finished_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_type  = req_type_q;
  assign req_row   = req_row_q;
  assign req_t     = req_t_q;
  assign req_dest  = req_dest_q;
  assign cur_t     = cur_t_q;
  assign ts_adv    = ts_adv_q;
  assign busy      = busy_q;
  assign finished  = finished_q;
  assign done_ovf  = ovf_q;

`ifdef SCHED_PERF_CNT_EN
  logic [15:0] stall_q, stall_d;
  logic        stall_evt;

  // A credit stall is a streaming cycle with no request, because the row needs
  // credit and none is available. Backpressure is any cycle with valid && !ready.
  assign stall_evt = (req_valid_q && !req_ready) ||
                     ((state_q == ST_STREAM) && !req_valid_q &&
                      (row_q >= ROW_FILT) && (cred_q == '0));

  always_comb begin
    stall_d = stall_q;
    if (ts_adv_d)
      stall_d = '0;
    else if (stall_evt && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign stall_cnt = stall_q;
`endif

endmodule
